// File: rtl/lsb_extractor.sv
// Recovers message words from the LSBs of audio sample frames. The first frame
// after start is a length header; that many payload words follow on a valid/ready stream.
module lsb_extractor #(
  parameter int BPS        = 16,
  parameter int FRAME_SIZE = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [FRAME_SIZE*BPS-1:0] in_frame,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [FRAME_SIZE-1:0]     out_message,
  output logic                      out_valid,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done,
  output logic [FRAME_SIZE-1:0]     length
);

  // state   | meaning
  // IDLE    | waiting for start after reset
  // HEADER  | accepting the length header frame
  // PAYLOAD | extracting payload frames into the output register
  // DONE    | message complete; waiting for start to re-arm
  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_DONE
  } state_t;

  state_t                state;
  logic [FRAME_SIZE-1:0] remaining;
  logic [FRAME_SIZE-1:0] lsb;
  logic                  in_xfer;
  logic                  out_xfer;

  always_comb begin
    lsb = '0;
    for (int k = 0; k < FRAME_SIZE; k++) begin
      lsb[k] = in_frame[k*BPS];
    end
  end

  // The output register may be refilled in the same cycle it drains.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_HEADER:  in_ready = 1'b1;
      S_PAYLOAD: in_ready = (remaining != '0) && (!out_valid || out_ready);
      default:   in_ready = 1'b0;
    endcase
  end

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign busy     = (state == S_HEADER) || (state == S_PAYLOAD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      remaining   <= '0;
      length      <= '0;
      out_message <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) state <= S_HEADER;
        end
        S_HEADER: begin
          if (in_xfer) begin
            length    <= lsb;
            remaining <= lsb;
            if (lsb == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          // in_xfer implies remaining != 0, so the decrement never wraps.
          if (in_xfer) begin
            out_message <= lsb;
            out_valid   <= 1'b1;
            out_last    <= (remaining == FRAME_SIZE'(1));
            remaining   <= remaining - FRAME_SIZE'(1);
          end else if (out_xfer) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          if (start) state <= S_HEADER;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsb_extractor.sv
// Directed bench for lsb_extractor: framing, backpressure, zero length,
// bit mapping, reset abort and restart behaviour.
module tb_lsb_extractor;
  localparam int BPS = 16;
  localparam int FS  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [FS*BPS-1:0] in_frame;
  logic              in_valid;
  logic              in_ready;
  logic [FS-1:0]     out_message;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic [FS-1:0]     length;

  int n_vec = 0;
  int n_err = 0;

  lsb_extractor #(.BPS(BPS), .FRAME_SIZE(FS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_frame(in_frame), .in_valid(in_valid), .in_ready(in_ready),
    .out_message(out_message), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .done(done), .length(length)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; checks happen 1ns after that.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [FS*BPS-1:0] mk(input logic [FS-1:0] bits, input bit rnd);
    logic [FS*BPS-1:0] f;
    logic [BPS-1:0]    s;
    f = '0;
    for (int k = 0; k < FS; k++) begin
      s = rnd ? BPS'($urandom) : '0;
      s[0] = bits[k];
      f[k*BPS +: BPS] = s;
    end
    return f;
  endfunction

  task automatic arm_header(input logic [FS-1:0] hdr);
    start = 1'b1;
    tick();
    start = 1'b0;
    in_frame = mk(hdr, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_frame = '0;
    tick(); tick();
    n_vec++;
    if ({in_ready, out_valid, out_last, busy, done} !== 5'b0 || out_message !== 8'h00 || length !== 8'h00) begin
      n_err++;
      $display("FAIL reset_outputs got rdy=%b v=%b l=%b busy=%b done=%b msg=%h len=%h exp all zero",
               in_ready, out_valid, out_last, busy, done, out_message, length);
    end
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_idle got busy=%b rdy=%b exp 0 0", busy, in_ready);
    end
  endtask

  task automatic test_basic();
    logic [FS-1:0] pl [3];
    pl[0] = 8'hA5; pl[1] = 8'h3C; pl[2] = 8'hFF;
    out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    in_frame = mk(8'h03, 1'b1); in_valid = 1'b1; settle();
    n_vec++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL basic_header_ready got rdy=%b busy=%b exp 1 1", in_ready, busy);
    end
    tick();
    n_vec++;
    if (length !== 8'h03 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_length got len=%h v=%b exp 03 0", length, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      in_frame = mk(pl[i], 1'b1); in_valid = 1'b1;
      tick();
      if (i == 2) in_valid = 1'b0;
      settle();
      n_vec++;
      if ({out_valid, out_last, out_message} !== {1'b1, (i == 2), pl[i]}) begin
        n_err++; $display("FAIL basic_word%0d got v=%b l=%b msg=%h exp 1 %0d %h",
                          i, out_valid, out_last, out_message, (i == 2), pl[i]);
      end
    end
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL basic_ready_after_last got %b exp 0", in_ready);
    end
    tick();
    n_vec++;
    if ({done, busy, out_valid} !== 3'b100 || length !== 8'h03) begin
      n_err++; $display("FAIL basic_done got done=%b busy=%b v=%b len=%h exp 1 0 0 03", done, busy, out_valid, length);
    end
    tick();
    n_vec++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL basic_done_pulse got %b exp 0", done);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    arm_header(8'h02);
    in_frame = mk(8'h11, 1'b1); in_valid = 1'b1;
    tick();
    out_ready = 1'b0;
    in_frame = mk(8'h22, 1'b1);
    for (int c = 0; c < 5; c++) begin
      settle();
      n_vec++;
      if ({in_ready, out_valid, out_last, out_message} !== {1'b0, 1'b1, 1'b0, 8'h11}) begin
        n_err++; $display("FAIL bp_hold%0d got rdy=%b v=%b l=%b msg=%h exp 0 1 0 11",
                          c, in_ready, out_valid, out_last, out_message);
      end
      tick();
    end
    out_ready = 1'b1; settle();
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_release_ready got %b exp 1", in_ready);
    end
    tick();
    in_valid = 1'b0; settle();
    n_vec++;
    if ({out_valid, out_last, out_message} !== {1'b1, 1'b1, 8'h22}) begin
      n_err++; $display("FAIL bp_second got v=%b l=%b msg=%h exp 1 1 22", out_valid, out_last, out_message);
    end
    tick();
    n_vec++;
    if ({done, out_valid} !== 2'b10) begin
      n_err++; $display("FAIL bp_done got done=%b v=%b exp 1 0", done, out_valid);
    end
  endtask

  task automatic test_zero_length();
    out_ready = 1'b1;
    arm_header(8'h00);
    n_vec++;
    if ({done, busy, out_valid} !== 3'b100 || length !== 8'h00) begin
      n_err++; $display("FAIL zero_done got done=%b busy=%b v=%b len=%h exp 1 0 0 00", done, busy, out_valid, length);
    end
    in_frame = mk(8'h77, 1'b0); in_valid = 1'b1; settle();
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL zero_not_accepted got rdy=%b exp 0", in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if ({out_valid, done, busy} !== 3'b000) begin
        n_err++; $display("FAIL zero_quiet%0d got v=%b done=%b busy=%b exp 0 0 0", c, out_valid, done, busy);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_bit_mapping();
    logic [FS*BPS-1:0] f;
    out_ready = 1'b1;
    arm_header(8'h02);
    for (int k = 0; k < FS; k++) f[k*BPS +: BPS] = (k == 5) ? 16'hFFFF : 16'hFFFE;
    in_frame = f; in_valid = 1'b1;
    tick();
    n_vec++;
    if ({out_valid, out_last, out_message} !== {1'b1, 1'b0, 8'h20}) begin
      n_err++; $display("FAIL map_bit5 got v=%b l=%b msg=%h exp 1 0 20", out_valid, out_last, out_message);
    end
    for (int k = 0; k < FS; k++) f[k*BPS +: BPS] = 16'h0001;
    in_frame = f;
    tick();
    in_valid = 1'b0; settle();
    n_vec++;
    if ({out_valid, out_last, out_message} !== {1'b1, 1'b1, 8'hFF}) begin
      n_err++; $display("FAIL map_all_ones got v=%b l=%b msg=%h exp 1 1 ff", out_valid, out_last, out_message);
    end
    tick();
  endtask

  task automatic test_reset_mid_payload();
    out_ready = 1'b1;
    arm_header(8'h04);
    in_frame = mk(8'h01, 1'b1); in_valid = 1'b1; tick();
    in_frame = mk(8'h02, 1'b1); tick();
    in_valid = 1'b0;
    rst_n = 1'b0; start = 1'b1;
    tick();
    n_vec++;
    if ({in_ready, out_valid, out_last, busy, done} !== 5'b0 || out_message !== 8'h00 || length !== 8'h00) begin
      n_err++;
      $display("FAIL midreset_outputs got rdy=%b v=%b l=%b busy=%b done=%b msg=%h len=%h exp all zero",
               in_ready, out_valid, out_last, busy, done, out_message, length);
    end
    rst_n = 1'b1; start = 1'b0;
    tick();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL midreset_start_dropped got busy=%b exp 0", busy);
    end
    arm_header(8'h01);
    in_frame = mk(8'h5A, 1'b1); in_valid = 1'b1;
    tick();
    in_valid = 1'b0; settle();
    n_vec++;
    if ({out_valid, out_last, out_message, length} !== {1'b1, 1'b1, 8'h5A, 8'h01}) begin
      n_err++; $display("FAIL midreset_word got v=%b l=%b msg=%h len=%h exp 1 1 5a 01", out_valid, out_last, out_message, length);
    end
    tick();
    n_vec++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL midreset_done got %b exp 1", done);
    end
  endtask

  task automatic test_restart();
    out_ready = 1'b1;
    arm_header(8'h02);
    in_frame = mk(8'h01, 1'b1); in_valid = 1'b1; tick();
    in_valid = 1'b0; start = 1'b1; tick();
    start = 1'b0; settle();
    n_vec++;
    if ({busy, out_valid, length} !== {1'b1, 1'b0, 8'h02} || in_ready !== 1'b1) begin
      n_err++; $display("FAIL restart_ignored got busy=%b v=%b len=%h rdy=%b exp 1 0 02 1", busy, out_valid, length, in_ready);
    end
    in_frame = mk(8'h02, 1'b1); in_valid = 1'b1; tick();
    in_valid = 1'b0; settle();
    n_vec++;
    if ({out_valid, out_last, out_message} !== {1'b1, 1'b1, 8'h02}) begin
      n_err++; $display("FAIL restart_last got v=%b l=%b msg=%h exp 1 1 02", out_valid, out_last, out_message);
    end
    tick();
    n_vec++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL restart_done got %b exp 1", done);
    end
    tick();
    start = 1'b1; tick(); start = 1'b0; settle();
    n_vec++;
    if (busy !== 1'b1 || length !== 8'h02) begin
      n_err++; $display("FAIL restart_len_held got busy=%b len=%h exp 1 02", busy, length);
    end
    in_frame = mk(8'hFF, 1'b1); in_valid = 1'b1; tick();
    n_vec++;
    if (length !== 8'hFF) begin
      n_err++; $display("FAIL restart_len255 got %h exp ff", length);
    end
    for (int i = 1; i <= 255; i++) begin
      in_frame = mk(8'(i), 1'b1); in_valid = 1'b1;
      tick();
      if (i == 255) in_valid = 1'b0;
      settle();
      n_vec++;
      if ({out_valid, out_last, out_message} !== {1'b1, (i == 255), 8'(i)}) begin
        n_err++; $display("FAIL long_word%0d got v=%b l=%b msg=%h exp 1 %0d %h",
                          i, out_valid, out_last, out_message, (i == 255), 8'(i));
      end
    end
    tick();
    n_vec++;
    if ({done, busy, out_valid} !== 3'b100) begin
      n_err++; $display("FAIL long_done got done=%b busy=%b v=%b exp 1 0 0", done, busy, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_length();
    test_bit_mapping();
    test_reset_mid_payload();
    test_restart();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
